// File: rtl/eq_cmp_arbiter_pkg.sv
// Shared types and constants for the two-requester compare arbiter.
package eq_cmp_arbiter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_CNT_W = 16;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Compare operation encodings
  localparam logic OP_EQ = 1'b0;
  localparam logic OP_NE = 1'b1;

  // Requester identifiers
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Turn a raw equality flag into the requested op's result
  function automatic logic apply_op(input logic eq, input logic op);
    logic res;
    case (op)
      OP_EQ:   res = eq;
      OP_NE:   res = ~eq;
      default: res = eq;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/eq_cmp_arbiter_if.sv
// Request/response bus between the two requesters and the compare arbiter.
interface eq_cmp_arbiter_if
  import eq_cmp_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
);

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_op;

  logic             rsp0_valid;
  logic             rsp1_valid;
  logic             rsp_result;
  logic             busy;
  logic [CNT_W-1:0] cmp_count;

  // Requester side
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, busy, cmp_count
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, busy, cmp_count
  );

endinterface

// File: rtl/eq_cmp_unit.sv
// Single shared WIDTH-bit equality comparator (purely combinational).
module eq_cmp_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq
);

  assign eq = (a == b);

endmodule

// File: rtl/eq_cmp_arbiter.sv
// Round-robin arbiter feeding one shared equality comparator.
// One compare in flight: IDLE accepts, CMP evaluates, RESP strobes the
// requester's response on the following cycle.
module eq_cmp_arbiter
  import eq_cmp_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  eq_cmp_arbiter_if.slave   bus
);

  state_t           r_state;
  logic             r_last;
  logic             r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_op;
  logic             r_result;
  logic             r_rsp0_valid;
  logic             r_rsp1_valid;
  logic             r_rsp_result;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;

  logic             w_idle;
  logic             w_win;
  logic             w_gnt0_c;
  logic             w_gnt1_c;
  logic             w_xfer;
  logic             w_eq;

  // Grant selection: tie goes to the requester not granted last
  always_comb begin
    w_idle   = rst_n & (r_state == IDLE);
    w_win    = (bus.req0_valid & bus.req1_valid) ? ~r_last : bus.req1_valid;
    w_gnt0_c = w_idle & bus.req0_valid & (w_win == REQ0);
    w_gnt1_c = w_idle & bus.req1_valid & (w_win == REQ1);
    w_xfer   = w_gnt0_c | w_gnt1_c;
  end

  eq_cmp_unit #(.WIDTH(WIDTH)) u_eq_cmp (
    .a  (r_a),
    .b  (r_b),
    .eq (w_eq)
  );

  // Sequencing FSM with latched job and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last       <= REQ1;
      r_id         <= REQ0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= OP_EQ;
      r_result     <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp_result <= 1'b0;
      r_busy       <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_state <= CMP;
            r_busy  <= 1'b1;
            r_id    <= w_win;
            r_last  <= w_win;
            r_a     <= (w_win == REQ1) ? bus.req1_a  : bus.req0_a;
            r_b     <= (w_win == REQ1) ? bus.req1_b  : bus.req0_b;
            r_op    <= (w_win == REQ1) ? bus.req1_op : bus.req0_op;
          end
        end
        CMP: begin
          r_state  <= RESP;
          r_result <= apply_op(w_eq, r_op);
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        RESP: begin
          r_state      <= IDLE;
          r_busy       <= 1'b0;
          r_rsp0_valid <= (r_id == REQ0);
          r_rsp1_valid <= (r_id == REQ1);
          r_rsp_result <= r_result;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req0_ready = w_gnt0_c;
  assign bus.req1_ready = w_gnt1_c;
  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.busy       = r_busy;
  assign bus.cmp_count  = r_cnt;

endmodule

// File: tb/tb_eq_cmp_arbiter.sv
// Bench for eq_cmp_arbiter: directed scenarios plus random traffic, checked
// against a timing model built from transfer-edge arithmetic.
module tb_eq_cmp_arbiter;
  import eq_cmp_arbiter_pkg::*;

  localparam int unsigned W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  eq_cmp_arbiter_if #(.WIDTH(W), .CNT_W(16)) bus  ();
  eq_cmp_arbiter_if #(.WIDTH(W), .CNT_W(2))  bus2 ();

  // Second instance (2-bit counter) sees the same requests
  assign bus2.req0_valid = bus.req0_valid;
  assign bus2.req0_a     = bus.req0_a;
  assign bus2.req0_b     = bus.req0_b;
  assign bus2.req0_op    = bus.req0_op;
  assign bus2.req1_valid = bus.req1_valid;
  assign bus2.req1_a     = bus.req1_a;
  assign bus2.req1_b     = bus.req1_b;
  assign bus2.req1_op    = bus.req1_op;

  eq_cmp_arbiter #(.WIDTH(W), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  eq_cmp_arbiter #(.WIDTH(W), .CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model: time since last transfer decides busy/ready/response
  int e      = 0;
  int m_xfer = -1;
  int m_id   = 0;
  int m_last = 1;
  int m_cnt  = 0;
  bit m_res  = 1'b0;

  bit log_grants = 1'b0;
  int grants[$];
  int obs_id  = -1;
  int obs_res = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic v1,
                       input logic [31:0] a0, input logic [31:0] b0, input logic op0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic op1);
    bus.req0_valid = v0;
    bus.req0_a     = a0;
    bus.req0_b     = b0;
    bus.req0_op    = op0;
    bus.req1_valid = v1;
    bus.req1_a     = a1;
    bus.req1_b     = b1;
    bus.req1_op    = op1;
  endtask

  task automatic model_reset();
    m_xfer = -1;
    m_last = 1;
    m_cnt  = 0;
  endtask

  // One clock: check at negedge, advance model at posedge, return at posedge+1
  task automatic step();
    bit free, r0, r1, exp_rsp0, exp_rsp1, n_res;
    int d;
    @(negedge clk);
    d    = e - m_xfer;
    free = (m_xfer < 0) || (d >= 2);
    r0   = rst_n && free && bus.req0_valid && (!bus.req1_valid || m_last == 1);
    r1   = rst_n && free && bus.req1_valid && (!bus.req0_valid || m_last == 0);
    exp_rsp0 = (m_xfer >= 0) && (d == 2) && (m_id == 0);
    exp_rsp1 = (m_xfer >= 0) && (d == 2) && (m_id == 1);
    check("req0_ready", 32'(bus.req0_ready), 32'(r0));
    check("req1_ready", 32'(bus.req1_ready), 32'(r1));
    check("busy", 32'(bus.busy), 32'(!free));
    check("rsp0_valid", 32'(bus.rsp0_valid), 32'(exp_rsp0));
    check("rsp1_valid", 32'(bus.rsp1_valid), 32'(exp_rsp1));
    check("cmp_count", 32'(bus.cmp_count), 32'(m_cnt % 65536));
    check("w2_rsp0_valid", 32'(bus2.rsp0_valid), 32'(exp_rsp0));
    check("w2_rsp1_valid", 32'(bus2.rsp1_valid), 32'(exp_rsp1));
    check("w2_cmp_count", 32'(bus2.cmp_count), 32'(m_cnt % 4));
    if (exp_rsp0 || exp_rsp1) begin
      check("rsp_result", 32'(bus.rsp_result), 32'(m_res));
      check("w2_rsp_result", 32'(bus2.rsp_result), 32'(m_res));
    end
    if (!rst_n) check("rsp_result_rst", 32'(bus.rsp_result), 32'd0);
    if (bus.rsp0_valid) begin obs_id = 0; obs_res = int'(bus.rsp_result); end
    if (bus.rsp1_valid) begin obs_id = 1; obs_res = int'(bus.rsp_result); end
    if (log_grants && bus.req0_valid && bus.req0_ready) grants.push_back(0);
    if (log_grants && bus.req1_valid && bus.req1_ready) grants.push_back(1);
    n_res = r1 ? ((bus.req1_a == bus.req1_b) ^ bus.req1_op)
               : ((bus.req0_a == bus.req0_b) ^ bus.req0_op);
    @(posedge clk);
    e++;
    if (r0 || r1) begin
      m_xfer = e;
      m_id   = r1 ? 1 : 0;
      m_last = m_id;
      m_res  = n_res;
    end
    if (m_xfer >= 0 && e == m_xfer + 1) m_cnt++;
    #1;
  endtask

  // Async reset mid-cycle, with both requesters pushing
  task automatic async_reset();
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ready0", 32'(bus.req0_ready), 32'd0);
    check("rst_ready1", 32'(bus.req1_ready), 32'd0);
    check("rst_rsp", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
    check("rst_count", 32'(bus.cmp_count), 32'd0);
    check("rst_count2", 32'(bus2.cmp_count), 32'd0);
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] a0, b0, a1, b1;
    drive(1'b1, 1'b1, 32'h0, 32'h0, OP_EQ, 32'h0, 32'h1, OP_EQ);
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;

    // Contention from reset: strict alternation, one grant every 3 cycles
    log_grants = 1'b1;
    grants.delete();
    repeat (12) step();
    log_grants = 1'b0;
    check("contend_ngrants", 32'(grants.size()), 32'd4);
    if (grants.size() == 4) begin
      check("contend_g0", 32'(grants[0]), 32'd0);
      check("contend_g1", 32'(grants[1]), 32'd1);
      check("contend_g2", 32'(grants[2]), 32'd0);
      check("contend_g3", 32'(grants[3]), 32'd1);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, OP_EQ, 32'h0, 32'h0, OP_EQ);
    repeat (3) step();

    // Reset while in CMP: no strobe, counter stays 0, tie goes to req0
    drive(1'b0, 1'b1, 32'h5, 32'h5, OP_EQ, 32'h9, 32'h9, OP_EQ);
    step();
    obs_id = -1;
    async_reset();
    check("abort_no_rsp", 32'(obs_id), 32'hFFFF_FFFF);
    log_grants = 1'b1;
    grants.delete();
    step();
    log_grants = 1'b0;
    check("abort_tie_n", 32'(grants.size()), 32'd1);
    if (grants.size() == 1) check("abort_tie_gnt", 32'(grants[0]), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, OP_EQ, 32'h0, 32'h0, OP_EQ);
    repeat (3) step();

    // Fresh reset then single EQ request on req0
    async_reset();
    drive(1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678, OP_EQ, 32'h0, 32'h0, OP_EQ);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h1, OP_NE, 32'h0, 32'h0, OP_EQ);
    obs_id = -1;
    repeat (3) step();
    check("single_id", 32'(obs_id), 32'd0);
    check("single_res", 32'(obs_res), 32'd1);
    check("single_cnt", 32'(bus.cmp_count), 32'd1);

    // NE op on req1, differing then equal operands
    drive(1'b0, 1'b1, 32'h0, 32'h0, OP_EQ, 32'hFFFF_FFFF, 32'h7FFF_FFFF, OP_NE);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, OP_EQ, 32'h0, 32'h0, OP_EQ);
    obs_id = -1;
    repeat (3) step();
    check("ne_diff_id", 32'(obs_id), 32'd1);
    check("ne_diff_res", 32'(obs_res), 32'd1);
    drive(1'b0, 1'b1, 32'h0, 32'h0, OP_EQ, 32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_NE);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, OP_EQ, 32'h0, 32'h0, OP_EQ);
    obs_id = -1;
    repeat (3) step();
    check("ne_same_id", 32'(obs_id), 32'd1);
    check("ne_same_res", 32'(obs_res), 32'd0);

    // Operands change right after transfer: latched values must be used
    drive(1'b1, 1'b0, 32'hA5A5_0001, 32'hA5A5_0001, OP_EQ, 32'h0, 32'h0, OP_EQ);
    step();
    drive(1'b0, 1'b0, 32'hA5A5_0002, 32'hA5A5_0001, OP_EQ, 32'h0, 32'h0, OP_EQ);
    obs_id = -1;
    repeat (3) step();
    check("hold_res", 32'(obs_res), 32'd1);
    check("wrap_cnt4", 32'(bus2.cmp_count), 32'd0);

    // Random traffic, including dropped valids and one mid-run reset
    for (int i = 0; i < 400; i++) begin
      a0 = $urandom();
      b0 = ($urandom_range(0, 1) == 0) ? a0 : (a0 ^ (32'h1 << $urandom_range(0, 31)));
      a1 = $urandom();
      b1 = ($urandom_range(0, 1) == 0) ? a1 : $urandom();
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
            a0, b0, 1'($urandom_range(0, 1)), a1, b1, 1'($urandom_range(0, 1)));
      if (i == 200) async_reset();
      else step();
    end

    drive(1'b0, 1'b0, 32'h0, 32'h0, OP_EQ, 32'h0, 32'h0, OP_EQ);
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
